// File: rtl/ir_nec_receiver.sv
// ir_nec_receiver -- NEC infrared remote-control frame decoder.
//
// Samples the demodulated IR line on a prescaled tick, measures each mark and
// space in ticks, and walks the NEC frame: 9 ms leader mark, then either a
// 4.5 ms space with 32 data bits or a 2.25 ms space (repeat code), then a stop mark.
//
// Parameters:
//   TICK_DIV    clk cycles per sample tick (2812 -> 56.25 us at 50 MHz)
//   HOLD_TICKS  ticks without a frame or repeat before `held` drops (~120 ms)
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   ir           asynchronous demodulated IR, low during a burst (mark)
//   code         command byte of the last accepted frame
//   addr         address byte of the last accepted frame
//   valid        one-cycle pulse when a new frame is accepted
//   repeat_code  one-cycle pulse on an accepted repeat code
//                (named so because `repeat` is a reserved word)
//   held         level, key considered pressed
//   err          one-cycle pulse on any aborted or rejected frame
//
// Build option:
//   IR_ADDR_CHECK_EN  when defined, byte1 must equal ~byte0 as well; when
//                     undefined, byte1 is ignored so extended-NEC frames pass.

module ir_nec_receiver #(
   parameter int TICK_DIV   = 2812,
   parameter int HOLD_TICKS = 2134
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ir,
   output logic [7:0] code,
   output logic [7:0] addr,
   output logic       valid,
   output logic       repeat_code,
   output logic       held,
   output logic       err
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = $clog2(HOLD_TICKS + 1);

   typedef enum logic [2:0] {
      IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
   } state_t;

   state_t         state;
   logic           ir_meta, ir_sync, ir_prev;
   logic [PW-1:0]  presc;
   logic [7:0]     phase_cnt;
   logic [31:0]    shreg;
   logic [4:0]     bit_idx;
   logic           is_rpt;
   logic [HW-1:0]  hold_cnt;
   logic           fall, rise, any_edge, tick, frame_ok;

   function automatic logic in_range(input logic [7:0] cnt, input int lo, input int hi);
      return (int'(cnt) >= lo) && (int'(cnt) <= hi);
   endfunction

   // Synchronizer flops idle high so reset never looks like the start of a mark.
   // NOTE: every clocked block uses non-blocking assignments so all registers
   // update together from the values sampled at the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ir_meta <= 1'b1;
         ir_sync <= 1'b1;
         ir_prev <= 1'b1;
      end else begin
         ir_meta <= ir;
         ir_sync <= ir_meta;
         ir_prev <= ir_sync;
      end
   end

   assign fall     = ir_prev & ~ir_sync;
   assign rise     = ~ir_prev & ir_sync;
   assign any_edge = fall | rise;
   // A tick never coincides with an edge: the edge restarts the prescaler.
   assign tick     = !any_edge && (presc == PW'(TICK_DIV - 1));

   // Command complement is always required; the address complement only when enabled.
`ifdef IR_ADDR_CHECK_EN
   assign frame_ok = (shreg[31:24] == ~shreg[23:16]) && (shreg[15:8] == ~shreg[7:0]);
`else
   assign frame_ok = (shreg[31:24] == ~shreg[23:16]);
`endif

   // Prescaler and phase-length counter, both restarted on every edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc     <= '0;
         phase_cnt <= '0;
      end else if (any_edge) begin
         presc     <= '0;
         phase_cnt <= '0;
      end else if (tick) begin
         presc <= '0;
         if (phase_cnt != 8'd255) phase_cnt <= phase_cnt + 8'd1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Frame FSM with registered pulse outputs; exactly one of valid,
   // repeat_code and err can be set in any branch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_idx     <= '0;
         is_rpt      <= 1'b0;
         code        <= '0;
         addr        <= '0;
         valid       <= 1'b0;
         repeat_code <= 1'b0;
         err         <= 1'b0;
      end else begin
         valid       <= 1'b0;
         repeat_code <= 1'b0;
         err         <= 1'b0;
         // A phase that runs to saturation aborts any frame in progress.
         if (state != IDLE && !any_edge && phase_cnt == 8'd255) begin
            err   <= 1'b1;
            state <= IDLE;
         end else begin
            case (state)
               IDLE: if (fall) state <= LEAD_MARK;
               LEAD_MARK: if (rise) begin
                  if (in_range(phase_cnt, 140, 180)) state <= LEAD_SPACE;
                  else begin err <= 1'b1; state <= IDLE; end
               end
               LEAD_SPACE: if (fall) begin
                  if (in_range(phase_cnt, 70, 90)) begin
                     state   <= BIT_MARK;
                     bit_idx <= '0;
                     is_rpt  <= 1'b0;
                  end else if (in_range(phase_cnt, 32, 48)) begin
                     state  <= STOP_MARK;
                     is_rpt <= 1'b1;
                  end else begin
                     err <= 1'b1; state <= IDLE;
                  end
               end
               BIT_MARK: if (rise) begin
                  if (in_range(phase_cnt, 6, 14)) state <= BIT_SPACE;
                  else begin err <= 1'b1; state <= IDLE; end
               end
               BIT_SPACE: if (fall) begin
                  if (in_range(phase_cnt, 6, 14) || in_range(phase_cnt, 24, 36)) begin
                     // LSB-first: new bit enters at the top and walks down to bit 0.
                     shreg   <= {in_range(phase_cnt, 24, 36), shreg[31:1]};
                     bit_idx <= bit_idx + 5'd1;
                     state   <= (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
                  end else begin
                     err <= 1'b1; state <= IDLE;
                  end
               end
               STOP_MARK: if (rise) begin
                  state <= IDLE;
                  if (!in_range(phase_cnt, 6, 14)) err <= 1'b1;
                  else if (is_rpt) begin
                     if (held) repeat_code <= 1'b1;
                     else      err         <= 1'b1;
                  end else if (frame_ok) begin
                     valid <= 1'b1;
                     code  <= shreg[23:16];
                     addr  <= shreg[7:0];
                  end else begin
                     err <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Key-held tracking: reloaded by each accepted frame or repeat, counts down per tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         held     <= 1'b0;
         hold_cnt <= '0;
      end else if (valid || repeat_code) begin
         held     <= 1'b1;
         hold_cnt <= HW'(HOLD_TICKS);
      end else if (tick && held) begin
         if (hold_cnt <= HW'(1)) begin
            held     <= 1'b0;
            hold_cnt <= '0;
         end else begin
            hold_cnt <= hold_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ir_nec_receiver.sv
// tb_ir_nec_receiver -- directed bench for ir_nec_receiver.
// A table of NEC frames with hand-computed outcomes, plus hand-written
// sequences for repeat codes, held timeout, leader timeout and mid-frame reset.

module tb_ir_nec_receiver;

   localparam int TICK_DIV   = 4;
   localparam int HOLD_TICKS = 4000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ir  = 1'b1;
   logic [7:0] code, addr;
   logic       valid, repeat_code, held, err;

   int n_vec  = 0;
   int n_miss = 0;
   int nv = 0, nr = 0, ne = 0, n_multi = 0;

   ir_nec_receiver #(.TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)) dut (
      .clk(clk), .rst(rst), .ir(ir), .code(code), .addr(addr),
      .valid(valid), .repeat_code(repeat_code), .held(held), .err(err)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled on the falling edge, away from register updates.
   always @(negedge clk) begin
      if (valid)       nv++;
      if (repeat_code) nr++;
      if (err)         ne++;
      if ((int'(valid) + int'(repeat_code) + int'(err)) > 1) n_multi++;
   end

   typedef struct {
      string      name;
      logic [7:0] b0, b1, b2, b3;
      int         exp_valid, exp_err;
      logic [7:0] exp_code, exp_addr;
      logic       exp_held;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic phase(input logic lvl, input int ticks);
      ir = lvl;
      repeat (ticks * TICK_DIV) @(negedge clk);
   endtask

   // Full frame when nbits == 32; otherwise stops partway through mark of bit nbits.
   task automatic send_frame(input logic [31:0] data, input int nbits);
      phase(1'b0, 160);
      phase(1'b1, 80);
      for (int i = 0; i < nbits; i++) begin
         phase(1'b0, 10);
         phase(1'b1, data[i] ? 30 : 10);
      end
      if (nbits == 32) phase(1'b0, 10);
      else             phase(1'b0, 5);
      if (nbits == 32) ir = 1'b1;
   endtask

   task automatic send_repeat();
      phase(1'b0, 160);
      phase(1'b1, 40);
      phase(1'b0, 10);
      ir = 1'b1;
   endtask

   task automatic gap();
      repeat (60) @(negedge clk);
   endtask

   initial begin
      int v0, e0, r0;
      bit seen;

      vecs[0] = '{"nec_00_45",   8'h00, 8'hFF, 8'h45, 8'hBA, 1, 0, 8'h45, 8'h00, 1'b1};
      vecs[1] = '{"nec_a5_ff",   8'hA5, 8'h5A, 8'hFF, 8'h00, 1, 0, 8'hFF, 8'hA5, 1'b1};
      vecs[2] = '{"bad_cmd_cpl", 8'h00, 8'hFF, 8'h45, 8'h00, 0, 1, 8'hFF, 8'hA5, 1'b1};
`ifdef IR_ADDR_CHECK_EN
      vecs[3] = '{"extended",    8'h04, 8'h10, 8'h08, 8'hF7, 0, 1, 8'hFF, 8'hA5, 1'b1};
`else
      vecs[3] = '{"extended",    8'h04, 8'h10, 8'h08, 8'hF7, 1, 0, 8'h08, 8'h04, 1'b1};
`endif
      vecs[4] = '{"nec_3c_00",   8'h3C, 8'hC3, 8'h00, 8'hFF, 1, 0, 8'h00, 8'h3C, 1'b1};

      // Reset state.
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_code",   code, 0);
      check("rst_addr",   addr, 0);
      check("rst_valid",  valid, 0);
      check("rst_repeat", repeat_code, 0);
      check("rst_err",    err, 0);
      check("rst_held",   held, 0);
      gap();

      // Repeat code while nothing is held is rejected.
      e0 = ne; r0 = nr;
      send_repeat();
      gap();
      check("rpt_noheld_err",    ne - e0, 1);
      check("rpt_noheld_repeat", nr - r0, 0);

      // Frame table.
      for (int i = 0; i < 5; i++) begin
         v0 = nv; e0 = ne;
         send_frame({vecs[i].b3, vecs[i].b2, vecs[i].b1, vecs[i].b0}, 32);
         gap();
         check({vecs[i].name, "_valid"}, nv - v0, vecs[i].exp_valid);
         check({vecs[i].name, "_err"},   ne - e0, vecs[i].exp_err);
         check({vecs[i].name, "_code"},  code, vecs[i].exp_code);
         check({vecs[i].name, "_addr"},  addr, vecs[i].exp_addr);
         check({vecs[i].name, "_held"},  held, vecs[i].exp_held);
      end

      // Accepted repeat, then held decays after HOLD_TICKS ticks of silence.
      v0 = nv; e0 = ne; r0 = nr;
      send_repeat();
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (repeat_code) seen = 1;
      end
      check("rpt_pulse_seen", seen, 1);
      check("rpt_held",       held, 1);
      check("rpt_no_err",     ne - e0, 0);
      check("rpt_no_valid",   nv - v0, 0);
      repeat (HOLD_TICKS * TICK_DIV - 10) @(negedge clk);
      check("hold_before_expiry", held, 1);
      repeat (20) @(negedge clk);
      check("hold_after_expiry", held, 0);
      check("rpt_count", nr - r0, 1);

      // Leader mark held far too long saturates the phase counter.
      v0 = nv; e0 = ne;
      phase(1'b0, 300);
      ir = 1'b1;
      gap();
      check("sat_err",   ne - e0, 1);
      check("sat_valid", nv - v0, 0);
      v0 = nv; e0 = ne;
      send_frame({8'hDD, 8'h22, 8'hEE, 8'h11}, 32);
      gap();
      check("post_sat_valid", nv - v0, 1);
      check("post_sat_err",   ne - e0, 0);
      check("post_sat_code",  code, 8'h22);
      check("post_sat_addr",  addr, 8'h11);

      // Reset in the middle of bit 17 drops the frame silently.
      e0 = ne; v0 = nv;
      send_frame({8'h99, 8'h66, 8'hAA, 8'h55}, 17);
      ir  = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_code", code, 0);
      check("midrst_addr", addr, 0);
      check("midrst_held", held, 0);
      repeat (200) @(negedge clk);
      check("midrst_no_err",   ne - e0, 0);
      check("midrst_no_valid", nv - v0, 0);
      v0 = nv;
      send_frame({8'h99, 8'h66, 8'hAA, 8'h55}, 32);
      gap();
      check("after_rst_valid", nv - v0, 1);
      check("after_rst_code",  code, 8'h66);
      check("after_rst_addr",  addr, 8'h55);
      check("after_rst_held",  held, 1);

      check("pulses_exclusive", n_multi, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
